// File: rtl/fetch_unit.sv
// fetch_unit: decoupled instruction prefetch queue between imem and decode.
// Redirects squash the queue and silently drain stale in-flight responses.
module fetch_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] instr_pc,
   output logic [XLEN-1:0] instr_pcplus4
);
   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned CW   = AW + 1;
   localparam logic [CW:0] FULL = (CW+1)'(DEPTH);

   logic [XLEN-1:0]             fetch_pc_q, fetch_pc_d;
   logic [DEPTH-1:0][XLEN-1:0]  pc_q, pc_d;
   logic [DEPTH-1:0][31:0]      data_q, data_d;
   logic [DEPTH-1:0]            filled_q, filled_d;
   logic [AW-1:0]               alloc_q, alloc_d;
   logic [AW-1:0]               fill_q, fill_d;
   logic [AW-1:0]               head_q, head_d;
   logic [CW-1:0]               count_q, count_d;
   logic [CW-1:0]               outst_q, outst_d;
   logic [CW-1:0]               drop_q, drop_d;

   logic [CW:0] occ;
   logic        req_fire;
   logic        rsp_fire;
   logic        head_ok;
   logic        pop;

   // Stale responses still occupy capacity until they drain.
   assign occ            = {1'b0, count_q} + {1'b0, drop_q};
   assign imem_req_valid = !reset && !redirect && (occ < FULL);
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign rsp_fire       = imem_rsp_valid && (outst_q != '0);
   assign head_ok        = (count_q != '0) && filled_q[head_q];
   assign pop            = head_ok && instr_ready;

   assign instr_valid   = head_ok;
   assign instr         = head_ok ? data_q[head_q] : '0;
   assign instr_pc      = head_ok ? pc_q[head_q] : '0;
   assign instr_pcplus4 = head_ok ? pc_q[head_q] + XLEN'(4) : '0;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      pc_d       = pc_q;
      data_d     = data_q;
      filled_d   = filled_q;
      alloc_d    = alloc_q;
      fill_d     = fill_q;
      head_d     = head_q;
      count_d    = count_q;
      outst_d    = outst_q;
      drop_d     = drop_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc & ~XLEN'(3);
         filled_d   = '0;
         alloc_d    = '0;
         fill_d     = '0;
         head_d     = '0;
         count_d    = '0;
         outst_d    = outst_q - CW'(rsp_fire);
         drop_d     = outst_q - CW'(rsp_fire);
      end else begin
         if (req_fire) begin
            pc_d[alloc_q]     = fetch_pc_q;
            filled_d[alloc_q] = 1'b0;
            alloc_d           = alloc_q + AW'(1);
            fetch_pc_d        = fetch_pc_q + XLEN'(4);
         end
         if (rsp_fire) begin
            if (drop_q != '0) begin
               drop_d = drop_q - CW'(1);
            end else begin
               data_d[fill_q]   = imem_rsp_data;
               filled_d[fill_q] = 1'b1;
               fill_d           = fill_q + AW'(1);
            end
         end
         if (pop) begin
            head_d = head_q + AW'(1);
         end
         count_d = count_q + CW'(req_fire) - CW'(pop);
         outst_d = outst_q + CW'(req_fire) - CW'(rsp_fire);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         pc_q       <= '0;
         data_q     <= '0;
         filled_q   <= '0;
         alloc_q    <= '0;
         fill_q     <= '0;
         head_q     <= '0;
         count_q    <= '0;
         outst_q    <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         pc_q       <= pc_d;
         data_q     <= data_d;
         filled_q   <= filled_d;
         alloc_q    <= alloc_d;
         fill_q     <= fill_d;
         head_q     <= head_d;
         count_q    <= count_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
      end
   end
endmodule
